// File: rtl/hcm_readout.sv
// rtl/hcm_readout.sv - HCM read-side sequencer: request credit control, tag pipe, decode, output FIFO
module hcm_readout #(
   parameter int ROWINDEXBITS_HCM = 10,
   parameter int NCOLS_HCM        = 11,
   parameter int MAXHITNBITS      = 3,
   parameter int ROWINDEXBITS_HIM = 8,
   parameter int HCM_READ_LATENCY = 3,
   parameter int FIFODEPTH        = 8
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_req_valid,
   input  logic [ROWINDEXBITS_HCM-1:0] i_req_row,
   input  logic                        i_req_last,
   output logic                        o_req_ready,
   input  logic                        i_hcm_write_row,
   input  logic                        i_hcm_read_ready,
   output logic                        o_read_row,
   output logic [ROWINDEXBITS_HCM-1:0] o_input_row_to_read,
   input  logic [ROWINDEXBITS_HCM-1:0] i_row_passed,
   input  logic [NCOLS_HCM-1:0]        i_row_read_output,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [ROWINDEXBITS_HCM-1:0] o_out_row,
   output logic [ROWINDEXBITS_HIM-1:0] o_out_him_address,
   output logic [MAXHITNBITS-1:0]      o_out_nhits,
   output logic                        o_out_last,
   output logic                        o_done,
   output logic                        o_err_mismatch,
   output logic [15:0]                 o_dropped_count
);

   localparam int PIPE = HCM_READ_LATENCY + 1;
   localparam int AW   = $clog2(FIFODEPTH);
   localparam int CW   = AW + 1;
   localparam int RW   = ROWINDEXBITS_HCM + ROWINDEXBITS_HIM + MAXHITNBITS + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                      r_state, w_state_next;
   logic [PIPE-1:0]             r_tag_vld;
   logic [PIPE-1:0]             r_tag_last;
   logic [ROWINDEXBITS_HCM-1:0] r_tag_row [PIPE];
   logic [CW-1:0]               r_inflight;
   logic [CW-1:0]               r_count;
   logic [AW-1:0]               r_wr_ptr, r_rd_ptr;
   logic [RW-1:0]               r_mem [FIFODEPTH];
   logic                        r_err;
   logic [15:0]                 r_dropped;

   logic                        w_accept, w_credit, w_cap, w_drop, w_push, w_pop, w_head_last;
   logic [ROWINDEXBITS_HCM-1:0] w_cap_row;
   logic [MAXHITNBITS-1:0]      w_nhits;
   logic [ROWINDEXBITS_HIM-1:0] w_addr;
   logic [RW-1:0]               w_head;

   // Credits cover both in-flight reads and buffered records, so the FIFO can never overflow.
   assign w_credit = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW+1)'(FIFODEPTH);
   assign o_req_ready = !i_reset && (r_state != S_DRAIN) && i_hcm_read_ready
                        && !i_hcm_write_row && w_credit;
   assign w_accept = i_req_valid && o_req_ready;
   assign o_read_row = w_accept;
   assign o_input_row_to_read = i_req_row;

   assign w_cap     = r_tag_vld[PIPE-1];
   assign w_cap_row = r_tag_row[PIPE-1];
   assign w_nhits   = i_row_read_output[MAXHITNBITS-1:0];
   assign w_addr    = i_row_read_output[NCOLS_HCM-1:MAXHITNBITS];
   // Empty rows are dropped, but the event's last record always goes out so the consumer sees outLast.
   assign w_drop    = w_cap && (w_nhits == '0) && !r_tag_last[PIPE-1];
   assign w_push    = w_cap && !w_drop;
   assign w_pop     = (r_count != '0) && i_out_ready;

   assign w_head = r_mem[r_rd_ptr];
   assign {o_out_row, o_out_him_address, o_out_nhits, w_head_last} = w_head;
   assign o_out_valid = (r_count != '0);
   assign o_out_last  = o_out_valid && w_head_last;
   assign o_err_mismatch  = r_err;
   assign o_dropped_count = r_dropped;

   // Tag valid bits: the tag reaches the last stage in the cycle hcmpp presents the data.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tag_vld <= '0;
      end else begin
         r_tag_vld[0] <= w_accept;
         for (int i = 1; i < PIPE; i++) r_tag_vld[i] <= r_tag_vld[i-1];
      end
   end

   // Tag payload shift; meaningful only where the matching valid bit is set.
   always_ff @(posedge i_clk) begin
      r_tag_row[0]  <= i_req_row;
      r_tag_last[0] <= i_req_last;
      for (int i = 1; i < PIPE; i++) begin
         r_tag_row[i]  <= r_tag_row[i-1];
         r_tag_last[i] <= r_tag_last[i-1];
      end
   end

   // In-flight counter, FIFO pointers/occupancy, mismatch flag and drop counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_inflight <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_err      <= 1'b0;
         r_dropped  <= '0;
      end else begin
         case ({w_accept, w_cap})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_cap && (i_row_passed != w_cap_row)) r_err <= 1'b1;
         if (o_done) r_dropped <= '0;
         else if (w_drop && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
      end
   end

   // FIFO storage; the record always carries the tag row, not the returned row.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_cap_row, w_addr, w_nhits, r_tag_last[PIPE-1]};
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // FSM next state and the drain-complete pulse.
   always_comb begin
      w_state_next = r_state;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = i_req_last ? S_DRAIN : S_RUN;
         end
         S_RUN: begin
            if (w_accept && i_req_last) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if ((r_inflight == '0) && (r_count == '0)) begin
               w_state_next = S_IDLE;
               o_done       = !i_reset;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hcm_readout.sv
// tb/tb_hcm_readout.sv - directed self-checking bench for hcm_readout
module tb_hcm_readout;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_last, req_ready;
   logic [9:0]  req_row;
   logic        write_row, read_ready, read_row;
   logic [9:0]  row_to_read, row_passed;
   logic [10:0] read_output;
   logic        out_valid, out_ready, out_last, done, err;
   logic [9:0]  out_row;
   logic [7:0]  out_addr;
   logic [2:0]  out_nhits;
   logic [15:0] dropped;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int acc;

   typedef struct packed {
      logic [9:0] row;
      logic [7:0] addr;
      logic [2:0] nh;
      logic       last;
   } rec_t;
   rec_t recs[$];

   logic [10:0] hmem [1024];
   logic [9:0]  p_row [4];
   logic [9:0]  bad_row;

   always #5 clk = ~clk;

   hcm_readout dut (
      .i_clk(clk), .i_reset(reset),
      .i_req_valid(req_valid), .i_req_row(req_row), .i_req_last(req_last), .o_req_ready(req_ready),
      .i_hcm_write_row(write_row), .i_hcm_read_ready(read_ready),
      .o_read_row(read_row), .o_input_row_to_read(row_to_read),
      .i_row_passed(row_passed), .i_row_read_output(read_output),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_row(out_row), .o_out_him_address(out_addr), .o_out_nhits(out_nhits),
      .o_out_last(out_last), .o_done(done), .o_err_mismatch(err), .o_dropped_count(dropped)
   );

   // hcmpp read model: data valid HCM_READ_LATENCY cycles after the sampling edge
   always @(posedge clk) begin
      p_row[0] <= read_row ? row_to_read : p_row[0];
      p_row[1] <= p_row[0];
      p_row[2] <= p_row[1];
      p_row[3] <= p_row[2];
   end
   assign row_passed  = (p_row[3] == bad_row) ? (p_row[3] ^ 10'd1) : p_row[3];
   assign read_output = hmem[p_row[3]];

   // record handshakes and done pulses, sampled half a cycle before the edge
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) recs.push_back({out_row, out_addr, out_nhits, out_last});
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [9:0] row, input logic last);
      bit ok = 0;
      req_row = row; req_last = last; req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (read_row) begin ok = 1; step(); break; end
         step();
      end
      req_valid = 1'b0;
      check("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_done();
      int start = done_cnt;
      for (int i = 0; i < 80; i++) begin
         if (done_cnt != start) break;
         step();
      end
      check("done_seen", 32'(done_cnt - start), 32'd1);
   endtask

   task automatic check_rec(input int i, input int row, input int addr, input int nh, input int last);
      if (i >= recs.size()) begin
         check("rec_present", 32'(recs.size()), 32'(i + 1));
      end else begin
         check("rec_row",   32'(recs[i].row),  32'(row));
         check("rec_addr",  32'(recs[i].addr), 32'(addr));
         check("rec_nhits", 32'(recs[i].nh),   32'(nh));
         check("rec_last",  32'(recs[i].last), 32'(last));
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) hmem[i] = 11'd0;
      for (int r = 10; r < 18; r++) hmem[r] = {8'(r + 100), 3'((r % 7) + 1)};
      hmem[5]  = {8'd17, 3'd2};
      hmem[18] = {8'd5, 3'd0};
      hmem[30] = {8'd60, 3'd1};
      hmem[31] = {8'd61, 3'd7};
      hmem[1]  = {8'd9, 3'd0};
      hmem[2]  = {8'd33, 3'd4};
      hmem[3]  = {8'd44, 3'd0};
      hmem[20] = {8'd70, 3'd3};
      hmem[21] = {8'd71, 3'd5};
      hmem[22] = {8'd72, 3'd6};
      hmem[50] = {8'd77, 3'd6};
      for (int i = 40; i < 45; i++) hmem[i] = {8'(i), 3'd1};
      bad_row = 10'h3FF;

      reset = 1; req_valid = 1; req_row = 10'd7; req_last = 0;
      write_row = 0; read_ready = 1; out_ready = 0;
      step(); step();
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_read_row",  32'(read_row), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last",  32'(out_last), 0);
      check("rst_done",      32'(done), 0);
      check("rst_err",       32'(err), 0);
      check("rst_dropped",   32'(dropped), 0);
      reset = 0; req_valid = 0;
      step();

      // single request, latency and done timing
      req_row = 10'd5; req_last = 1; req_valid = 1;
      #1 check("t1_read_row", 32'(read_row), 1);
      step();
      req_valid = 0;
      for (int i = 0; i < 4; i++) begin
         check("t1_latency_low", 32'(out_valid), 0);
         step();
      end
      check("t1_out_valid", 32'(out_valid), 1);
      check("t1_row",   32'(out_row), 5);
      check("t1_addr",  32'(out_addr), 17);
      check("t1_nhits", 32'(out_nhits), 2);
      check("t1_last",  32'(out_last), 1);
      check("t1_done_early", 32'(done), 0);
      out_ready = 1;
      step();
      check("t1_done_pulse", 32'(done), 1);
      check("t1_empty", 32'(out_valid), 0);
      step();
      check("t1_done_single", 32'(done), 0);
      check("t1_nrec", 32'(recs.size()), 1);

      // credit limit with the output stalled
      recs.delete(); out_ready = 0; acc = 0; req_valid = 1;
      for (int i = 0; i < 12; i++) begin
         req_row = 10'(10 + acc); req_last = 0;
         #1 if (read_row) acc++;
         step();
      end
      check("t2_accepts", 32'(acc), 8);
      check("t2_ready_low", 32'(req_ready), 0);
      out_ready = 1;
      for (int i = 0; i < 20; i++) begin
         if (acc == 9) break;
         req_row = 10'(10 + acc); req_last = (acc == 8);
         #1 if (read_row) acc++;
         step();
      end
      req_valid = 0;
      check("t2_ready_back", 32'(acc), 9);
      wait_done();
      check("t2_nrec", 32'(recs.size()), 9);
      for (int k = 0; k < 8; k++) check_rec(k, 10 + k, 110 + k, ((10 + k) % 7) + 1, 0);
      check_rec(8, 18, 5, 0, 1);

      // hcmpp write holds off reads
      recs.delete();
      write_row = 1; req_valid = 1; req_row = 10'd30; req_last = 0;
      for (int i = 0; i < 3; i++) begin
         #1 check("t3_no_read", 32'(read_row), 0);
         @(posedge clk); #1;
      end
      write_row = 0; req_valid = 0;
      send(10'd30, 0);
      send(10'd31, 1);
      wait_done();
      check("t3_nrec", 32'(recs.size()), 2);
      check_rec(0, 30, 60, 1, 0);
      check_rec(1, 31, 61, 7, 1);

      // empty-row dropping, last always kept
      recs.delete(); out_ready = 0;
      send(10'd1, 0); send(10'd2, 0); send(10'd3, 1);
      for (int i = 0; i < 6; i++) step();
      check("t4_dropped", 32'(dropped), 1);
      out_ready = 1;
      wait_done();
      check("t4_dropped_clr", 32'(dropped), 0);
      check("t4_nrec", 32'(recs.size()), 2);
      check_rec(0, 2, 33, 4, 0);
      check_rec(1, 3, 44, 0, 1);

      // row mismatch on the second of three reads
      recs.delete(); bad_row = 10'd21;
      check("t5_err_before", 32'(err), 0);
      send(10'd20, 0); send(10'd21, 0); send(10'd22, 1);
      wait_done();
      bad_row = 10'h3FF;
      for (int i = 0; i < 5; i++) step();
      check("t5_err_sticky", 32'(err), 1);
      check_rec(0, 20, 70, 3, 0);
      check_rec(1, 21, 71, 5, 0);
      check_rec(2, 22, 72, 6, 1);

      // reset with records buffered and reads in flight
      recs.delete(); out_ready = 0;
      send(10'd40, 0); send(10'd41, 0); send(10'd42, 0);
      for (int i = 0; i < 5; i++) step();
      send(10'd43, 0); send(10'd44, 0);
      reset = 1; req_valid = 1; req_row = 10'd45;
      step();
      check("t6_rst_valid", 32'(out_valid), 0);
      check("t6_rst_last",  32'(out_last), 0);
      check("t6_rst_done",  32'(done), 0);
      check("t6_rst_err",   32'(err), 0);
      check("t6_rst_ready", 32'(req_ready), 0);
      check("t6_rst_read",  32'(read_row), 0);
      reset = 0; req_valid = 0;
      for (int i = 0; i < 8; i++) step();
      check("t6_stale_ignored", 32'(out_valid), 0);
      check("t6_stale_err", 32'(err), 0);
      out_ready = 1;
      send(10'd50, 1);
      wait_done();
      check("t6_nrec", 32'(recs.size()), 1);
      check_rec(0, 50, 77, 6, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
